// File: rtl/usb_cmd_led.sv
// usb_cmd_led: parses "<R|G|B><hex><hex><CR|LF>" from a byte stream, answers K/E, drives RGB PWM
module usb_cmd_led #(
  parameter int PWM_BITS = 8
) (
  input  logic       clk48,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       led_r,
  output logic       led_g,
  output logic       led_b
);
  typedef enum logic [2:0] {IDLE, HI, LO, TERM, ERR, RESP} state_e;
  state_e state_q, state_d;
  logic [1:0] sel_q, sel_d, idx_q, idx_d, ch;
  logic ok_q, ok_d, wr, acc, eol, is_ch, is_hex;
  logic [3:0] hi_q, hi_d, lo_q, lo_d, hex;
  logic [7:0] lc;
  logic [2:0][PWM_BITS-1:0] duty_q, act_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic [2:0] led_q;

  // Folding bit 5 makes letter matching case-insensitive without affecting digits.
  assign lc = in_data | 8'h20;
  assign acc = in_valid & in_ready;
  assign eol = in_data == 8'h0D || in_data == 8'h0A;
  assign is_ch = lc == "r" || lc == "g" || lc == "b";
  assign ch = lc == "r" ? 2'd0 : lc == "g" ? 2'd1 : 2'd2;
  assign is_hex = (in_data >= "0" && in_data <= "9") || (lc >= "a" && lc <= "f");
  assign hex = in_data[6] ? in_data[3:0] + 4'd9 : in_data[3:0];
  assign in_ready = state_q != RESP && !reset;
  assign out_valid = state_q == RESP;
  assign out_data = !out_valid ? 8'h00 : idx_q == 2'd0 ? (ok_q ? 8'h4B : 8'h45) : idx_q == 2'd1 ? 8'h0D : 8'h0A;
  assign {led_b, led_g, led_r} = led_q;

  // Parser next state; the response byte index restarts whenever RESP is entered.
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    idx_d = idx_q;
    ok_d = ok_q;
    hi_d = hi_q;
    lo_d = lo_q;
    wr = 1'b0;
    case (state_q)
      IDLE: if (acc) begin
        if (is_ch) begin
          state_d = HI;
          sel_d = ch;
        end else if (!eol) state_d = ERR;
      end
      HI: if (acc) begin
        state_d = is_hex ? LO : eol ? RESP : ERR;
        hi_d = is_hex ? hex : hi_q;
        idx_d = 2'd0;
        ok_d = 1'b0;
      end
      LO: if (acc) begin
        state_d = is_hex ? TERM : eol ? RESP : ERR;
        lo_d = is_hex ? hex : lo_q;
        idx_d = 2'd0;
        ok_d = 1'b0;
      end
      TERM: if (acc) begin
        state_d = eol ? RESP : ERR;
        wr = eol;
        idx_d = 2'd0;
        ok_d = 1'b1;
      end
      ERR: if (acc && eol) begin
        state_d = RESP;
        idx_d = 2'd0;
        ok_d = 1'b0;
      end
      default: if (out_ready) begin
        state_d = idx_q == 2'd2 ? IDLE : RESP;
        idx_d = idx_q + 2'd1;
      end
    endcase
  end

  // Parser state and command fields.
  always_ff @(posedge clk48 or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      sel_q <= '0;
      idx_q <= '0;
      ok_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      idx_q <= idx_d;
      ok_q <= ok_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end

  // Duty registers change only when a complete command is terminated.
  always_ff @(posedge clk48 or posedge reset)
    if (reset) duty_q <= '0;
    else for (int i = 0; i < 3; i++) if (wr && sel_q == 2'(i)) duty_q[i] <= PWM_BITS'({hi_q, lo_q});

  // Free-running PWM; duties are latched at the wrap so every period is whole.
  always_ff @(posedge clk48 or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      act_q <= '0;
      led_q <= '0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      if (&cnt_q) act_q <= duty_q;
      for (int i = 0; i < 3; i++) led_q[i] <= cnt_q < act_q[i];
    end
endmodule

// File: tb/tb_usb_cmd_led.sv
// tb_usb_cmd_led: directed command/response and PWM duty checks for usb_cmd_led
module tb_usb_cmd_led;
  logic clk48 = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1, rnd = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, out_valid, led_r, led_g, led_b;
  logic [7:0] out_data;
  int n_chk = 0, n_fail = 0, viol = 0, hold_err = 0;
  logic [7:0] rx_q[$];
  logic pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;

  always #10 clk48 = ~clk48;

  usb_cmd_led #(.PWM_BITS(8)) dut (
    .clk48(clk48), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .led_r(led_r), .led_g(led_g), .led_b(led_b)
  );

  always @(posedge clk48) begin
    if (!reset && pv && !pr && (!out_valid || out_data !== pd)) hold_err <= hold_err + 1;
    if (out_valid && out_ready) rx_q.push_back(out_data);
    pv <= out_valid && !reset;
    pr <= out_ready;
    pd <= out_data;
  end

  always @(negedge clk48) if (out_valid && in_ready) viol <= viol + 1;

  always @(posedge clk48) begin
    #1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r = 1'b0;
    int k = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!r && k < 200) begin
      @(negedge clk48);
      r = in_ready;
      @(posedge clk48);
      #1;
      k++;
    end
    in_valid = 1'b0;
    if (!r) check("send_timeout", 0, 1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_rx(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 500) begin
      @(posedge clk48);
      #1;
      k++;
    end
    if (rx_q.size() < n) check("rx_timeout", rx_q.size(), n);
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return i < rx_q.size() ? rx_q[i] : 8'hxx;
  endfunction

  task automatic expect_resp(input string tag, input int base, input logic ok);
    wait_rx(base + 3);
    check({tag, "_b0"}, rx_at(base), ok ? 8'h4B : 8'h45);
    check({tag, "_b1"}, rx_at(base + 1), 8'h0D);
    check({tag, "_b2"}, rx_at(base + 2), 8'h0A);
  endtask

  task automatic duty_cnt(input string tag, input int er, input int eg, input int eb);
    int r = 0, g = 0, b = 0;
    repeat (600) @(posedge clk48);
    repeat (256) begin
      @(negedge clk48);
      r += int'(led_r);
      g += int'(led_g);
      b += int'(led_b);
    end
    @(posedge clk48);
    #1;
    check({tag, "_r"}, r, er);
    check({tag, "_g"}, g, eg);
    check({tag, "_b"}, b, eb);
  endtask

  initial begin
    repeat (3) @(negedge clk48);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_leds", {led_r, led_g, led_b}, 0);
    reset = 1'b0;
    @(negedge clk48);
    check("rdy_after_rst", in_ready, 1);
    @(posedge clk48);
    #1;
    send_str("RFF");
    send_byte(8'h0D);
    expect_resp("rff", 0, 1'b1);
    duty_cnt("rff", 255, 0, 0);
    send_str("g80");
    send_byte(8'h0A);
    expect_resp("g80", 3, 1'b1);
    duty_cnt("g80", 255, 128, 0);
    send_str("RZ9");
    send_byte(8'h0D);
    expect_resp("rz9", 6, 1'b0);
    send_str("B1");
    send_byte(8'h0D);
    expect_resp("b1", 9, 1'b0);
    duty_cnt("err", 255, 128, 0);
    send_byte(8'h0D);
    send_byte(8'h0A);
    repeat (20) @(posedge clk48);
    #1;
    check("bare_eol_rx", rx_q.size(), 12);
    check("bare_eol_rdy", in_ready, 1);
    rnd = 1'b1;
    send_str("B40");
    send_byte(8'h0D);
    send_str("G10");
    send_byte(8'h0D);
    expect_resp("b40", 12, 1'b1);
    expect_resp("g10", 15, 1'b1);
    rnd = 1'b0;
    repeat (10) @(posedge clk48);
    #1;
    check("b2b_rx_count", rx_q.size(), 18);
    check("rdy_in_resp", viol, 0);
    check("out_hold", hold_err, 0);
    duty_cnt("b2b", 255, 16, 64);
    send_str("R01");
    send_byte(8'h0D);
    wait_rx(20);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_leds", {led_r, led_g, led_b}, 0);
    repeat (3) @(posedge clk48);
    @(negedge clk48);
    reset = 1'b0;
    repeat (20) @(posedge clk48);
    #1;
    check("mid_rst_no_tail", rx_q.size(), 20);
    send_str("R01");
    send_byte(8'h0D);
    expect_resp("r01", 20, 1'b1);
    duty_cnt("r01", 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
